// File: rtl/shift_req_pipe.sv
// Request FIFO and output register around a combinational barrel shifter.
// The FIFO head feeds the shifter, and each result is captured with a valid/ready handshake.
module shift_req_pipe #(
   parameter int N     = 8,
   parameter int M     = 3,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [N-1:0]               in_a,
   input  logic [M-1:0]               in_amt,
   input  logic                       in_lr,
   output logic [N-1:0]               shf_a,
   output logic [M-1:0]               shf_amt,
   output logic                       shf_lr,
   input  logic [N-1:0]               shf_y,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [N-1:0]               out_data,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = N + M + 1;

   logic [EW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          out_valid_q, out_valid_d;
   logic [N-1:0]  out_data_q, out_data_d;
   logic          push_s, load_s, not_empty_s;
   logic [EW-1:0] head_s;

   // Handshake decode and head selection; the head reads registered storage only.
   always_comb begin
      not_empty_s = (count_q != {CW{1'b0}});
      in_ready    = (count_q != CW'(DEPTH));
      push_s      = in_valid && in_ready;
      load_s      = not_empty_s && (!out_valid_q || out_ready);
      if (not_empty_s) begin
         head_s = mem_q[rd_ptr_q];
      end else begin
         head_s = {EW{1'b0}};
      end
      shf_a   = head_s[EW-1 -: N];
      shf_amt = head_s[M:1];
      shf_lr  = head_s[0];
   end

   // Next-state for pointers, occupancy and the output register.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (load_s) begin
         rd_ptr_d    = rd_ptr_q + PW'(1);
         out_data_d  = shf_y;
         out_valid_d = 1'b1;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
      case ({push_s, load_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state; reset discards buffered requests and any pending result.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q    <= {PW{1'b0}};
         rd_ptr_q    <= {PW{1'b0}};
         count_q     <= {CW{1'b0}};
         out_valid_q <= 1'b0;
         out_data_q  <= {N{1'b0}};
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   // Request storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= {in_a, in_amt, in_lr};
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign count     = count_q;

endmodule

// File: tb/tb_shift_req_pipe.sv
// Self-checking bench for shift_req_pipe with an attached rotate shifter and a
// transaction-level queue model plus an in-order result scoreboard.
module tb_shift_req_pipe;
   localparam int N = 8, M = 3, DEPTH = 4;

   logic clk, reset_n, in_valid, in_ready, in_lr, shf_lr, out_valid, out_ready;
   logic [N-1:0] in_a, shf_a, shf_y, out_data;
   logic [M-1:0] in_amt, shf_amt;
   logic [2:0]   count;

   shift_req_pipe #(.N(N), .M(M), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_amt(in_amt), .in_lr(in_lr), .shf_a(shf_a), .shf_amt(shf_amt),
      .shf_lr(shf_lr), .shf_y(shf_y), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .count(count));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Attached shifter: rotate via a doubled word.
   logic [15:0] dbl_s, shl_s, shr_s;
   always_comb begin
      dbl_s = {shf_a, shf_a};
      shl_s = dbl_s << shf_amt;
      shr_s = dbl_s >> shf_amt;
      shf_y = shf_lr ? shl_s[15:8] : shr_s[7:0];
   end

   typedef struct { logic [7:0] a; logic [2:0] amt; logic lr; } req_t;
   typedef struct { logic [7:0] a; logic [2:0] amt; logic lr; logic [7:0] exp; } vec_t;

   req_t       mq[$];
   logic [7:0] sbq[$];
   logic       m_valid;
   logic [7:0] m_data;
   int checks = 0, errors = 0;
   int n_acc = 0, n_push = 0, n_cons = 0;

   function automatic logic [7:0] ref_rot(input logic [7:0] a, input int s, input logic left);
      logic [7:0] r;
      r = a;
      for (int i = 0; i < s; i++) r = left ? {r[6:0], r[7]} : {r[0], r[7:1]};
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      sbq.delete();
      m_valid = 1'b0;
      m_data  = 8'h00;
   endtask

   // One clock: pre-edge checks, edge, model update, post-edge checks.
   task automatic cycle();
      req_t r;
      logic push, load;
      logic [11:0] hexp;
      hexp = (mq.size() != 0) ? {mq[0].a, mq[0].amt, mq[0].lr} : 12'h000;
      chk("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
      chk("head", 32'({shf_a, shf_amt, shf_lr}), 32'(hexp));
      push = in_valid && (mq.size() != DEPTH);
      load = (mq.size() != 0) && (!m_valid || out_ready);
      if (in_valid && in_ready) n_acc++;
      if (out_valid && out_ready) begin
         n_cons++;
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_extra: got result %0h expected none", out_data);
         end else begin
            chk("sb_order", 32'(out_data), 32'(sbq.pop_front()));
         end
      end
      r.a = in_a; r.amt = in_amt; r.lr = in_lr;
      @(posedge clk);
      if (load) begin
         m_data  = ref_rot(mq[0].a, int'(mq[0].amt), mq[0].lr);
         m_valid = 1'b1;
         void'(mq.pop_front());
      end else if (m_valid && out_ready) begin
         m_valid = 1'b0;
      end
      if (push) begin
         mq.push_back(r);
         sbq.push_back(ref_rot(r.a, int'(r.amt), r.lr));
         n_push++;
      end
      #1;
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("count", 32'(count), 32'(mq.size()));
   endtask

   vec_t vecs[6];
   int run, maxrun, tot, maxc, a0, c0, p0, guard;

   initial begin
      vecs[0] = '{8'h81, 3'd1, 1'b0, 8'hC0};
      vecs[1] = '{8'h81, 3'd1, 1'b1, 8'h03};
      vecs[2] = '{8'h81, 3'd0, 1'b0, 8'h81};
      vecs[3] = '{8'hF0, 3'd4, 1'b1, 8'h0F};
      vecs[4] = '{8'h01, 3'd7, 1'b0, 8'h02};
      vecs[5] = '{8'h80, 3'd7, 1'b1, 8'h40};

      reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_a = 8'h00; in_amt = 3'd0; in_lr = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);
      reset_n = 1'b1;

      // Single-request latency and shifter results from the table.
      foreach (vecs[i]) begin
         in_valid = 1'b1; in_a = vecs[i].a; in_amt = vecs[i].amt; in_lr = vecs[i].lr;
         out_ready = 1'b0;
         cycle();
         chk("lat_k_valid", 32'(out_valid), 32'd0);
         in_valid = 1'b0;
         cycle();
         chk("lat_k1_valid", 32'(out_valid), 32'd1);
         chk("tbl_data", 32'(out_data), 32'(vecs[i].exp));
         out_ready = 1'b1;
         cycle();
         chk("tbl_drain", 32'(out_valid), 32'd0);
      end

      // Streaming: 16 back-to-back requests.
      run = 0; maxrun = 0; tot = 0; maxc = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_valid = (i < 16);
         in_a = 8'($urandom); in_amt = 3'($urandom_range(0, 7)); in_lr = 1'($urandom);
         cycle();
         if (out_valid) begin tot++; run++; end else run = 0;
         if (run > maxrun) maxrun = run;
         if (int'(count) > maxc) maxc = int'(count);
      end
      chk("stream_total", 32'(tot), 32'd16);
      chk("stream_run", 32'(maxrun), 32'd16);
      chk("stream_cnt_le1", 32'(maxc <= 1), 32'd1);

      // Fill under back-pressure.
      a0 = n_acc;
      out_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_a = 8'($urandom); in_amt = 3'($urandom_range(0, 7)); in_lr = 1'($urandom);
         cycle();
      end
      chk("fill_accepts", 32'(n_acc - a0), 32'd5);
      chk("fill_count", 32'(count), 32'd4);
      chk("fill_ready", 32'(in_ready), 32'd0);

      // Full with simultaneous pop: push refused, then accepted next edge.
      a0 = n_acc;
      out_ready = 1'b1; in_valid = 1'b1;
      cycle();
      chk("fullpop_acc", 32'(n_acc - a0), 32'd0);
      chk("fullpop_cnt", 32'(count), 32'd3);
      cycle();
      chk("fullpop_acc2", 32'(n_acc - a0), 32'd1);
      chk("fullpop_cnt2", 32'(count), 32'd3);
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) cycle();
      chk("fill_drained", 32'(sbq.size()), 32'd0);

      // Wrap-around with random traffic and back-pressure.
      p0 = n_push; c0 = n_cons; guard = 0;
      while ((n_push - p0) < 3 * DEPTH && guard < 500) begin
         in_valid = 1'($urandom); out_ready = 1'($urandom);
         in_a = 8'($urandom); in_amt = 3'($urandom_range(0, 7)); in_lr = 1'($urandom);
         cycle();
         guard++;
      end
      if (guard >= 500) chk("wrap_timeout", 32'(n_push - p0), 32'(3 * DEPTH));
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 2 * DEPTH + 4; i++) cycle();
      chk("wrap_consumed", 32'(n_cons - c0), 32'(3 * DEPTH));
      chk("wrap_sb_empty", 32'(sbq.size()), 32'd0);

      // Asynchronous reset mid-transfer with count = 3.
      out_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_a = 8'($urandom); in_amt = 3'($urandom_range(1, 7)); in_lr = 1'($urandom);
         cycle();
      end
      chk("pre_rst_count", 32'(count), 32'd3);
      in_valid = 1'b0;
      #3 reset_n = 1'b0;
      #1;
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_data", 32'(out_data), 32'd0);
      chk("arst_count", 32'(count), 32'd0);
      chk("arst_ready", 32'(in_ready), 32'd1);
      chk("arst_shf", 32'({shf_a, shf_amt, shf_lr}), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      in_valid = 1'b1; in_a = 8'h81; in_amt = 3'd1; in_lr = 1'b0;
      cycle();
      chk("post_rst_acc", 32'(count), 32'd1);
      in_valid = 1'b0;
      cycle();
      chk("post_rst_data", 32'(out_data), 32'hC0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
